// File: rtl/wisc_pkg.sv
// Shared constants and state encoding for the cache block fill path.
package wisc_pkg;
   localparam int ADDR_W      = 16;
   localparam int BLOCK_WORDS = 8;
   localparam int MEM_LATENCY = 4;
   localparam int CNT_W       = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;
endpackage

// File: rtl/dff.sv
// Team register cell: async active-high reset, write enable.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wen,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else if (wen) q_q <= d;
   end

   assign q = q_q;
endmodule

// File: rtl/fill_counter.sv
// Small up-counter with synchronous clear and saturation at SAT.
module fill_counter #(
   parameter int           W   = 4,
   parameter logic [W-1:0] SAT = W'(8)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) cnt_d = '0;
      else if (en && (cnt_q < SAT)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block fill: issues back-to-back word reads and
// forwards returned words into the data array, tag on the last.
module cache_fill_fsm #(
   parameter int ADDR_W      = 16,
   parameter int BLOCK_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              memory_read,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [2:0]        fill_word,
   output logic [15:0]       fill_data,
   output logic              write_tag_array,
   output logic              fill_done
);
   import wisc_pkg::*;

   localparam logic [0:0] S_IDLE = 1'(IDLE);
   localparam logic [0:0] S_FILL = 1'(FILL);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK =
      ADDR_W'(2 * BLOCK_WORDS - 1);

   logic [0:0]        state_q;
   logic [0:0]        state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;
   logic [CNT_W-1:0]  req_cnt_q;
   logic [CNT_W-1:0]  rcv_cnt_q;

   logic start;
   logic in_fill;
   logic req_en;
   logic rcv_en;
   logic last_word;

   assign in_fill   = (state_q == S_FILL);
   assign start     = (state_q == S_IDLE) && miss_detected;
   assign req_en    = in_fill && (req_cnt_q < LIMIT);
   assign rcv_en    = in_fill && memory_data_valid
                      && (rcv_cnt_q < LIMIT);
   assign last_word = rcv_en && (rcv_cnt_q == LAST);

   // Block-aligned base; offset bits of the missing address dropped.
   assign base_d = miss_address & ~OFF_MASK;

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         start:     state_d = S_FILL;
         last_word: state_d = S_IDLE;
         default:   state_d = state_q;
      endcase
   end

   dff #(.W(1)) u_state (
      .clk (clk),
      .rst (rst),
      .wen (1'b1),
      .d   (state_d),
      .q   (state_q)
   );

   dff #(.W(ADDR_W)) u_base (
      .clk (clk),
      .rst (rst),
      .wen (start),
      .d   (base_d),
      .q   (base_q)
   );

   fill_counter #(.W(CNT_W), .SAT(LIMIT)) u_req_cnt (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (req_en),
      .cnt (req_cnt_q)
   );

   fill_counter #(.W(CNT_W), .SAT(LIMIT)) u_rcv_cnt (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (rcv_en),
      .cnt (rcv_cnt_q)
   );

   // Outputs are forced low while rst is held, not just after the edge.
   always_comb begin
      fsm_busy         = 1'b0;
      memory_read      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      fill_word        = 3'd0;
      fill_data        = 16'd0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;
      if (!rst) begin
         fsm_busy    = start || in_fill;
         memory_read = req_en;
         if (req_en) begin
            memory_address = base_q
                             + ADDR_W'({req_cnt_q, 1'b0});
         end
         write_data_array = rcv_en;
         if (rcv_en) begin
            fill_word = rcv_cnt_q[2:0];
            fill_data = memory_data;
         end
         write_tag_array = last_word;
         fill_done       = last_word;
      end
   end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with hand-timed memory returns.
module tb_cache_fill_fsm;
   import wisc_pkg::*;

   logic        clk;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        memory_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic        fill_done;

   int n_checks = 0;
   int n_errors = 0;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read       (memory_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_word         (fill_word),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic m, input logic [15:0] a,
                        input logic v, input logic [15:0] d);
      miss_detected     = m;
      miss_address      = a;
      memory_data_valid = v;
      memory_data       = d;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, 32'(fsm_busy), 0);
      check({tag, " read"}, 32'(memory_read), 0);
      check({tag, " addr"}, 32'(memory_address), 0);
      check({tag, " wr"}, 32'(write_data_array), 0);
      check({tag, " data"}, 32'(fill_data), 0);
      check({tag, " tag"}, 32'(write_tag_array), 0);
      check({tag, " done"}, 32'(fill_done), 0);
   endtask

   task automatic fill_run(input string name,
                           input logic [15:0] miss_a,
                           input logic [15:0] exp_base,
                           input logic [15:0] dbase,
                           input bit noisy);
      logic [15:0] ea;
      logic [15:0] ed;
      bit er;
      bit ew;
      drive(1'b1, miss_a, 1'b0, 16'h0);
      check($sformatf("%s c0 busy", name), 32'(fsm_busy), 1);
      check($sformatf("%s c0 read", name), 32'(memory_read), 0);
      check($sformatf("%s c0 wr", name), 32'(write_data_array), 0);
      tick();
      for (int c = 1; c <= 12; c++) begin
         ew = (c >= 1 + MEM_LATENCY);
         ed = dbase + 16'(c - 1 - MEM_LATENCY);
         er = (c <= 8);
         ea = exp_base + 16'(2 * (c - 1));
         drive(noisy && c[0], 16'h5550, ew, ew ? ed : 16'h0);
         check($sformatf("%s c%0d busy", name, c), 32'(fsm_busy), 1);
         check($sformatf("%s c%0d read", name, c),
               32'(memory_read), 32'(er));
         if (er)
            check($sformatf("%s c%0d addr", name, c),
                  32'(memory_address), 32'(ea));
         check($sformatf("%s c%0d wr", name, c),
               32'(write_data_array), 32'(ew));
         if (ew) begin
            check($sformatf("%s c%0d word", name, c),
                  32'(fill_word), 32'(c - 1 - MEM_LATENCY));
            check($sformatf("%s c%0d data", name, c),
                  32'(fill_data), 32'(ed));
         end
         check($sformatf("%s c%0d tag", name, c),
               32'(write_tag_array), 32'(c == 12));
         check($sformatf("%s c%0d done", name, c),
               32'(fill_done), 32'(c == 12));
         tick();
      end
   endtask

   task automatic idle_cycle(input string name);
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      check({name, " idle busy"}, 32'(fsm_busy), 0);
      check({name, " idle read"}, 32'(memory_read), 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      miss_detected = 1'b1;
      miss_address = 16'h1236;
      memory_data_valid = 1'b1;
      memory_data = 16'hDEAD;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      tick();
      rst = 1'b0;

      drive(1'b0, 16'h0, 1'b1, 16'hDEAD);
      check("spurious wr", 32'(write_data_array), 0);
      check("spurious busy", 32'(fsm_busy), 0);
      check("spurious tag", 32'(write_tag_array), 0);
      tick();

      fill_run("basic", 16'h1236, 16'h1230, 16'hA000, 1'b0);
      fill_run("b2b", 16'h2000, 16'h2000, 16'hB000, 1'b0);
      idle_cycle("b2b");
      fill_run("noisy", 16'h1236, 16'h1230, 16'hC000, 1'b1);
      idle_cycle("noisy");

      for (int c = 0; c <= 5; c++) begin
         drive(c == 0, 16'h1236, c >= 5, 16'h9000);
         if (c >= 1)
            check($sformatf("rstmid c%0d addr", c),
                  32'(memory_address), 32'(16'h1230 + 16'(2 * (c - 1))));
         tick();
      end
      miss_detected = 1'b0;
      memory_data_valid = 1'b1;
      memory_data = 16'h9001;
      rst = 1'b1;
      #1;
      check_all_zero("rstmid async");
      tick();
      rst = 1'b0;
      for (int c = 7; c <= 10; c++) begin
         drive(1'b0, 16'h0, 1'b1, 16'h9000 + 16'(c - 5));
         check($sformatf("late c%0d wr", c), 32'(write_data_array), 0);
         check($sformatf("late c%0d busy", c), 32'(fsm_busy), 0);
         check($sformatf("late c%0d done", c), 32'(fill_done), 0);
         tick();
      end
      fill_run("after_rst", 16'h0040, 16'h0040, 16'hD000, 1'b0);
      idle_cycle("after_rst");
      fill_run("wrap", 16'hFFFE, 16'hFFF0, 16'hE000, 1'b0);
      idle_cycle("wrap");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
